// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the ID-stage issue controller: state encoding and default widths.
package id_ctrl_pkg;

    localparam int unsigned BUS_W_DEF = 64;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } id_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import id_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: holds one IF instruction, tracks hazard readiness,
// hands off to EXE and counts stall cycles.
module id_issue_ctrl
    import id_ctrl_pkg::*;
#(
    parameter int unsigned BUS_W = BUS_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs_to_ds_valid,
    input  logic [BUS_W-1:0] fs_to_ds_bus,
    input  logic             es_allow_in,
    input  logic             hazard,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             ds_allow_in,
    output logic             ds_to_es_valid,
    output logic [BUS_W-1:0] ds_bus,
    output logic             id_ready_go,
    output logic [CNT_W-1:0] stall_cnt
);

    id_state_e state_q;
    id_state_e state_nxt;
    logic      bus_we;
    logic      stall_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ds_bus  <= '0;
        end else begin
            state_q <= state_nxt;
            if (bus_we) begin
                ds_bus <= fs_to_ds_bus;
            end
        end
    end

    // READY latches readiness so a late hazard cannot pull back an instruction already offered to EXE.
    always_comb begin
        state_nxt      = state_q;
        id_ready_go    = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_allow_in    = 1'b0;
        stall_inc      = 1'b0;
        bus_we         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fs_to_ds_valid) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                id_ready_go = !hazard;
                if (!hazard && es_allow_in) begin
                    state_nxt = fs_to_ds_valid ? ST_WAIT : ST_IDLE;
                end else if (!hazard) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                id_ready_go = 1'b1;
                if (es_allow_in) begin
                    state_nxt = fs_to_ds_valid ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_nxt = ST_IDLE;
        end

        ds_to_es_valid = id_ready_go && !flush;
        ds_allow_in    = (state_q == ST_IDLE) || flush || (id_ready_go && es_allow_in);
        bus_we         = ds_allow_in && fs_to_ds_valid && !flush;
        stall_inc      = (state_q != ST_IDLE) && !flush && !(id_ready_go && es_allow_in);
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

endmodule
